// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-back, single-word-line data cache for the memory stage (DCACHE_STATS_EN adds hit/miss counters).
// Latency: hits are zero-wait; a miss stalls for writeback ack latency (dirty victim only) + fill ack latency + 1 cycle.
// Backpressure: stall freezes the pipeline until the miss completes; the backing memory paces each transfer with mem_ack.
module dcache_responder #(
   parameter int INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] writeData,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic        halt,
   output logic [15:0] readData,
   output logic        stall,
   output logic        err,
`ifdef DCACHE_STATS_EN
   output logic [15:0] hit_count,
   output logic [15:0] miss_count,
`endif
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 15 - INDEX_BITS;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, RESPOND} state_t;
   state_t state, nextState;

   logic [LINES-1:0]    valid, dirty;
   logic [TAG_BITS-1:0] tagArr  [LINES];
   logic [15:0]         dataArr [LINES];

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   addrTag, lineTag;
   logic [15:0]           lineData;
   logic                  req, legal, hit, idleHit, idleMiss;

   assign idx      = addr[INDEX_BITS:1];
   assign addrTag  = addr[15:INDEX_BITS+1];
   assign lineTag  = tagArr[idx];
   assign lineData = dataArr[idx];
   assign req      = (memRead ^ memWrite) & ~halt;
   assign legal    = req & ~addr[0];
   assign hit      = valid[idx] & (lineTag == addrTag);
   assign idleHit  = (state == IDLE) & legal & hit;
   assign idleMiss = (state == IDLE) & legal & ~hit;

   always_comb begin
      nextState = state;
      stall     = 1'b0;
      readData  = '0;
      err       = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            if ((memRead & memWrite & ~halt) | (req & addr[0])) err = 1'b1;
            if (idleHit & memRead) readData = lineData;
            if (idleMiss) begin
               stall     = 1'b1;
               nextState = (valid[idx] & dirty[idx]) ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            stall     = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = {lineTag, idx, 1'b0};
            mem_wdata = lineData;
            if (mem_ack) nextState = ALLOCATE;
         end
         ALLOCATE: begin
            stall    = 1'b1;
            mem_rd   = 1'b1;
            mem_addr = {addr[15:1], 1'b0};
            if (mem_ack) nextState = RESPOND;
         end
         RESPOND: begin
            if (memRead) readData = lineData;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
      // An ack with no transfer outstanding means the backing side is confused.
      if (mem_ack && (state == IDLE || state == RESPOND)) err = 1'b1;
      if (!rst) begin
         stall     = 1'b0;
         readData  = '0;
         err       = 1'b0;
         mem_rd    = 1'b0;
         mem_wr    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         valid <= '0;
         dirty <= '0;
      end else begin
         state <= nextState;
         case (state)
            IDLE:      if (idleHit & memWrite) dirty[idx] <= 1'b1;
            WRITEBACK: if (mem_ack) dirty[idx] <= 1'b0;
            ALLOCATE:  if (mem_ack) begin
                          valid[idx] <= 1'b1;
                          dirty[idx] <= 1'b0;
                       end
            RESPOND:   if (memWrite) dirty[idx] <= 1'b1;
            default:   ;
         endcase
      end
   end

   // Tag/data arrays carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if ((idleHit | (state == RESPOND)) & memWrite) begin
         dataArr[idx] <= writeData;
      end else if ((state == ALLOCATE) & mem_ack) begin
         dataArr[idx] <= mem_rdata;
         tagArr[idx]  <= addrTag;
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (idleHit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
         if (idleMiss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
   end
`endif

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Memory-side responder to the pipeline's memory stage.
- Receives the stage's read/write requests (addr, writeData, memRead, memWrite, halt) and returns readData and the memStall signal that freezes the pipeline registers.
- Implemented as a direct-mapped, write-back, single-word-line data cache.
- A req/ack initiator port toward a slow backing main memory services misses.

Parameters:
- INDEX_BITS, 4, log2 of line count (16 lines); index = addr[INDEX_BITS:1], tag = addr[15:INDEX_BITS+1].

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- addr  in  16  byte address of access (word aligned)
- writeData  in  16  store data
- memRead  in  1  load request
- memWrite  in  1  store request
- halt  in  1  halting instruction in memory stage; no access is performed
- readData  out  16  load data
- stall  out  1  memStall to pipeline; held high until the request completes
- err  out  1  illegal request flag
- mem_addr  out  16  backing memory address
- mem_wdata  out  16  backing write data
- mem_rd  out  1  backing read request
- mem_wr  out  1  backing write request
- mem_rdata  in  16  backing read data, valid with mem_ack during a read
- mem_ack  in  1  backing completion, single-cycle pulse

Behaviour:
- Storage: per line valid, dirty, tag, data.
- Reset (rst low, asynchronous): state IDLE; all valid and dirty bits cleared; tag/data arrays are not reset.
- Output reset values: stall=0, readData=0, err=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Request: req = (memRead ^ memWrite) & ~halt.
- hit = valid[idx] & (tag[idx] == addr tag).
- Requester holds addr, writeData, memRead and memWrite stable while stall=1.
- IDLE:
  - No req: stall=0, readData=0.
  - req & hit: stall=0 combinationally, zero-wait.
    - Read: readData = data[idx] in the same cycle.
    - Write: data[idx] <= writeData and dirty[idx] <= 1 at the clock edge.
  - req & miss: stall=1 combinationally.
    - Next state WRITEBACK if valid & dirty, else ALLOCATE.
- WRITEBACK:
  - stall=1, mem_wr=1, mem_addr={tag[idx], idx, 1'b0}, mem_wdata=data[idx].
  - On mem_ack: dirty[idx] <= 0, go to ALLOCATE.
- ALLOCATE:
  - stall=1, mem_rd=1, mem_addr={addr[15:1], 1'b0}.
  - On mem_ack: data[idx] <= mem_rdata, tag updated, valid=1, dirty=0; go to RESPOND.
- RESPOND: exactly one cycle, stall=0, request served as a hit (read data driven, or write merged with dirty set); next state IDLE.
- Outside WRITEBACK/ALLOCATE: mem_rd=mem_wr=0 and mem_addr/mem_wdata=0.
- Miss latency = ack latency of the writeback (if any) + ack latency of the fill + 1.
- Illegal requests, flagged combinationally while present in IDLE:
  - memRead & memWrite both high: err=1, no access, stall=0.
  - addr[0]=1 with req: err=1, no access, stall=0.
- halt with memRead/memWrite: no access, stall=0, err=0.
- mem_ack in IDLE or RESPOND: ignored; err=1 for that cycle.
- Reset during WRITEBACK/ALLOCATE: mem_rd/mem_wr drop immediately, the transfer is abandoned, and all lines become invalid.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined, adds outputs hit_count[15:0] and miss_count[15:0]; both reset to 0.
  - hit_count increments on every IDLE req&hit cycle.
  - miss_count increments on every IDLE→WRITEBACK/ALLOCATE transition.
  - Both saturate at 16'hFFFF.
  - RESPOND cycles count as neither.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Cold read miss: after reset, memRead addr=16'h0010, backing returns 16'hBEEF with mem_ack 3 cycles after mem_rd → stall=1 for 4 cycles, mem_addr=16'h0010, then one cycle stall=0 with readData=16'hBEEF; repeat read → zero-wait hit, readData=16'hBEEF.
- Write hit, dirty eviction:
  - Stimulus: write 16'h1234 to 16'h0010 (hit after fill), then read 16'h0030 (same index 8, different tag).
  - Response: WRITEBACK with mem_wr=1, mem_addr=16'h0010, mem_wdata=16'h1234, then ALLOCATE with mem_addr=16'h0030.
- Clean eviction: read 16'h0002, then read 16'h0022 → no mem_wr, only mem_rd to 16'h0022.
- Illegal requests:
  - memRead=memWrite=1 → err=1, stall=0, no mem_rd/mem_wr.
  - addr=16'h0005 with memRead → err=1.
  - halt=1 with memWrite → no access, err=0.
- Async reset mid-ALLOCATE: drop rst with mem_rd=1 → mem_rd=0 immediately; after release, the previously cached address misses.
- DCACHE_STATS_EN: 3 hits + 2 misses → hit_count=3, miss_count=2; after reset both are 0.
